// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: 4-deep byte FIFO feeding an 11-bit framer.
// Host inhibit aborts a frame before its stop-bit falling edge; the byte is then resent.
module ps2_kbd_tx #(
    parameter int HALF_DIV   = 512,
    parameter int GAP_HALVES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic [2:0] fifo_count
);
    localparam int GAP_CYC = GAP_HALVES * HALF_DIV;
    localparam int CMAX    = (GAP_CYC > HALF_DIV) ? GAP_CYC : HALF_DIV;
    localparam int CW      = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          low_q, low_d;
    logic [10:0]   frame_q, frame_d;
    logic          clk_q, clk_d, data_q, data_d, busy_q, busy_d, rdy_q, rdy_d;
    logic [2:0]    count_q, count_d;
    logic [1:0]    wp_q, wp_d, rp_q, rp_d;
    logic          avail_q, avail_d;
    logic [7:0]    mem_q [4];
    logic          push, pop;

    always_comb begin
        push    = din_valid & rdy_q;
        pop     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        low_d   = low_q;
        frame_d = frame_q;
        clk_d   = clk_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                // avail_q lags the count by one edge, giving a two-edge start latency
                if (avail_q && !inhibit) begin
                    state_d = S_SEND;
                    frame_d = {1'b1, ~^mem_q[rp_q], mem_q[rp_q], 1'b0};
                    bit_d   = 4'd0;
                    low_d   = 1'b0;
                    cnt_d   = '0;
                    clk_d   = 1'b1;
                    data_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (inhibit && !(low_q && bit_q == 4'd10)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    clk_d   = 1'b1;
                    data_d  = 1'b1;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        low_d = 1'b1;
                        clk_d = 1'b0;
                    end else if (bit_q == 4'd10) begin
                        state_d = S_GAP;
                        pop     = 1'b1;
                        clk_d   = 1'b1;
                        data_d  = 1'b1;
                    end else begin
                        low_d   = 1'b0;
                        clk_d   = 1'b1;
                        bit_d   = bit_q + 4'd1;
                        data_d  = frame_q[1];
                        frame_d = {1'b1, frame_q[10:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // HOLD: the quiet period restarts every time the host re-inhibits
                if (inhibit) begin
                    cnt_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        count_d = count_q + 3'(push) - 3'(pop);
        rdy_d   = (count_d < 3'd4);
        wp_d    = wp_q + 2'(push);
        rp_d    = rp_q + 2'(pop);
        avail_d = (count_q != 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            low_q   <= 1'b0;
            frame_q <= '1;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            count_q <= 3'd0;
            wp_q    <= 2'd0;
            rp_q    <= 2'd0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            low_q   <= low_d;
            frame_q <= frame_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            count_q <= count_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            avail_q <= avail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end

    assign din_ready  = rdy_q;
    assign ps2_clk    = clk_q;
    assign ps2_data   = data_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
endmodule
